// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   DEFAULT_ADDRESS_WIDTH / DEFAULT_INS_WIDTH : default PC and instruction widths
//   NOP_INSTR      : encoding used for pipeline bubbles (addi x0,x0,0)
//   fetch_state_t  : fetch FSM states
//   if_id_t        : IF/ID pipeline register payload
package fetch_pkg;

    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 8;
    localparam int unsigned DEFAULT_INS_WIDTH     = 32;

    localparam logic [DEFAULT_INS_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEFAULT_INS_WIDTH-1:0]     instr;
        logic [DEFAULT_ADDRESS_WIDTH-1:0] pc;
        logic [DEFAULT_ADDRESS_WIDTH-1:0] pc_plus4;
        logic                             valid;
    } if_id_t;

    // Bubble payload; also the reset value of the IF/ID register.
    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, async active-low reset (resets to bubble)
//   bubble_i   : load a bubble (highest priority)
//   load_i     : load data_i
//   data_i     : payload to load
//   q_o        : registered payload
// With neither control asserted the register holds.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   bubble_i,
    input  logic   load_i,
    input  if_id_t data_i,
    output if_id_t q_o
);

    if_id_t ifid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= IF_ID_BUBBLE;
        end else if (bubble_i) begin
            ifid_q <= IF_ID_BUBBLE;
        end else if (load_i) begin
            ifid_q <= data_i;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and captures
// the returned instruction into the IF/ID register.
//   clk, rst_n          : clock, async active-low reset
//   rom_addr / rom_data : ROM byte address (= PC) and its combinational data
//   stall               : decode back-pressure, hold PC and IF/ID
//   redirect/redirect_pc: taken branch/jump target (low two bits dropped)
//   halt                : stop fetching until reset
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID outputs to decode
//   misalign            : one-cycle flag, last redirect target was unaligned
//   halted              : FSM is in HALTED
// The IF/ID payload struct is sized by the package defaults; the width
// parameters here are expected to match them.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned INS_WIDTH     = DEFAULT_INS_WIDTH,
    parameter int unsigned RESET_PC      = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [INS_WIDTH-1:0]     rom_data,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt,
    output logic [INS_WIDTH-1:0]     instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d,
    output logic                     misalign,
    output logic                     halted
);

    fetch_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                       misalign_q, misalign_d;
    logic [ADDRESS_WIDTH-1:0]   pc_inc;
    logic                       ifid_load, ifid_bubble;
    if_id_t                     ifid_data, ifid_q;

    assign pc_inc = ADDRESS_WIDTH'(fetch_pc_q + ADDRESS_WIDTH'(4));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a redirect in the same cycle defers halt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt && !redirect) state_d = HALTED;
            default: state_d = state_q;
        endcase
    end

    // Fetch controls: redirect > halt > stall > normal fetch, RUN only.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        misalign_d  = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_data   = ifid_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    fetch_pc_d  = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
                    misalign_d  = |redirect_pc[1:0];
                    ifid_bubble = 1'b1;
                end else if (halt) begin
                    // Entering HALTED: keep IF/ID contents but mark them dead.
                    ifid_load       = 1'b1;
                    ifid_data.valid = 1'b0;
                end else if (!stall) begin
                    fetch_pc_d         = pc_inc;
                    ifid_load          = 1'b1;
                    ifid_data.instr    = DEFAULT_INS_WIDTH'(rom_data);
                    ifid_data.pc       = DEFAULT_ADDRESS_WIDTH'(fetch_pc_q);
                    ifid_data.pc_plus4 = DEFAULT_ADDRESS_WIDTH'(pc_inc);
                    ifid_data.valid    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // PC and misalign flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= ADDRESS_WIDTH'(RESET_PC);
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (ifid_bubble),
        .load_i   (ifid_load),
        .data_i   (ifid_data),
        .q_o      (ifid_q)
    );

    assign rom_addr   = fetch_pc_q;
    assign instr_d    = INS_WIDTH'(ifid_q.instr);
    assign pc_d       = ADDRESS_WIDTH'(ifid_q.pc);
    assign pc_plus4_d = ADDRESS_WIDTH'(ifid_q.pc_plus4);
    assign valid_d    = ifid_q.valid;
    assign misalign   = misalign_q;
    assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID and
// status values; one entry is pushed per step and popped after the edge.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic [31:0] instr_d;
    logic [7:0]  pc_d;
    logic [7:0]  pc_plus4_d;
    logic        valid_d;
    logic        misalign;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  pc;
        logic [7:0]  pc4;
        logic        valid;
        logic [7:0]  addr;
        logic        mis;
        logic        hlt;
        logic        chk_pc;
    } exp_t;

    exp_t sb[$];

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .misalign    (misalign),
        .halted      (halted)
    );

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        if (a == 8'h00) return 32'h0050_0093;
        if (a == 8'h04) return 32'h0010_0113;
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [7:0] p, input logic [7:0] p4,
                        input logic v, input logic [7:0] a, input logic m, input logic h,
                        input logic cp);
        exp_t e;
        e.instr = i; e.pc = p; e.pc4 = p4; e.valid = v;
        e.addr = a; e.mis = m; e.hlt = h; e.chk_pc = cp;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"},    instr_d,  e.instr);
            chk({tag, "_valid"},    valid_d,  32'(e.valid));
            chk({tag, "_rom_addr"}, rom_addr, 32'(e.addr));
            chk({tag, "_misalign"}, misalign, 32'(e.mis));
            chk({tag, "_halted"},   halted,   32'(e.hlt));
            if (e.chk_pc) begin
                chk({tag, "_pc"},       pc_d,       32'(e.pc));
                chk({tag, "_pc_plus4"}, pc_plus4_d, 32'(e.pc4));
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; halt = 1'b0;

        // Reset state, then BOOT cycle with no capture.
        #12;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_now("reset");
        rst_n = 1'b1;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle("boot");

        // Free run from 0x00.
        push(32'h0050_0093, 8'h00, 8'h04, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
        cycle("fetch0");
        push(32'h0010_0113, 8'h04, 8'h08, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
        cycle("fetch4");
        push(rom_word(8'h08), 8'h08, 8'h0C, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1);
        cycle("fetch8");

        // Stall for three cycles, then resume at 0x0C.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(rom_word(8'h08), 8'h08, 8'h0C, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1);
            cycle("stall");
        end
        stall = 1'b0;
        push(rom_word(8'h0C), 8'h0C, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        cycle("resume");

        // Redirect overrides stall.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0);
        cycle("redir_stall");
        stall = 1'b0; redirect = 1'b0;
        push(rom_word(8'h40), 8'h40, 8'h44, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
        cycle("redir_target");

        // Misaligned redirect target.
        redirect = 1'b1; redirect_pc = 8'h23;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0);
        cycle("misalign");
        redirect = 1'b0;
        push(rom_word(8'h20), 8'h20, 8'h24, 1'b1, 8'h24, 1'b0, 1'b0, 1'b1);
        cycle("misalign_clear");

        // PC wrap around 0xFC -> 0x00.
        redirect = 1'b1; redirect_pc = 8'hF8;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0);
        cycle("redir_f8");
        redirect = 1'b0;
        push(rom_word(8'hF8), 8'hF8, 8'hFC, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b1);
        cycle("wrap_f8");
        push(rom_word(8'hFC), 8'hFC, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle("wrap_fc");
        push(32'h0050_0093, 8'h00, 8'h04, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
        cycle("wrap_00");

        // Halt at pc_d=0x10; redirect is ignored once halted.
        redirect = 1'b1; redirect_pc = 8'h10;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        cycle("redir_10");
        redirect = 1'b0;
        push(rom_word(8'h10), 8'h10, 8'h14, 1'b1, 8'h14, 1'b0, 1'b0, 1'b1);
        cycle("fetch10");
        halt = 1'b1;
        push(rom_word(8'h10), 8'h10, 8'h14, 1'b0, 8'h14, 1'b0, 1'b1, 1'b1);
        cycle("halt");
        halt = 1'b0; redirect = 1'b1; redirect_pc = 8'h80;
        push(rom_word(8'h10), 8'h10, 8'h14, 1'b0, 8'h14, 1'b0, 1'b1, 1'b1);
        cycle("halted_redir");
        redirect = 1'b0;

        // Asynchronous reset mid-cycle, no clock edge needed.
        #3 rst_n = 1'b0;
        #1;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_now("async_reset");
        #1 rst_n = 1'b1;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle("boot2");
        push(32'h0050_0093, 8'h00, 8'h04, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
        cycle("fetch0_2");

        // Halt with redirect: redirect wins, halt re-sampled next cycle.
        halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h30;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        cycle("halt_redir");
        // Halt with stall: enter HALTED, valid cleared.
        redirect = 1'b0; stall = 1'b1;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0);
        cycle("halt_stall");
        halt = 1'b0; stall = 1'b0;
        push(NOP, 8'h00, 8'h00, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0);
        cycle("halted_hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
